uart_rx_ctrl: RTL

//  Controller between the UART receiver datapath and a host. Holds the line configuration in shadow

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_rx_ctrl_if.sv | 57 +++++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_rx_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller (and the TX side that reuses the FIFO).
//   - FSM state encoding of the RX controller
//   - bit offsets of the line-control fields inside the host config word; offsets are relative to
//     the top of the clock-divisor field, which always sits at cfgData[W-1:0]
//   - reset-default line configuration (8 data bits, no parity, mode 00, one stop bit)
//   - FIFO entry layout {break, parityError, data[8:0]}
package uart_pkg;

  typedef enum logic [2:0] {
    StApplyRst,
    StApplyWait,
    StIdle,
    StAck,
    StWaitClr
  } rxCtrlState_e;

  // Line-control fields above the divisor: {dataBits[1:0], hasParity, parityMode[1:0], extraStopBit}
  localparam int unsigned CfgExtraStopOfs  = 0;
  localparam int unsigned CfgParityModeOfs = 1;
  localparam int unsigned CfgHasParityOfs  = 3;
  localparam int unsigned CfgDataBitsOfs   = 4;
  localparam int unsigned CfgCtrlBits      = 6;

  localparam logic [1:0] RstDataBits     = 2'd3;
  localparam logic       RstHasParity    = 1'b0;
  localparam logic [1:0] RstParityMode   = 2'b00;
  localparam logic       RstExtraStopBit = 1'b0;

  localparam int unsigned FifoEntryWidth = 11;

  typedef struct packed {
    logic       brk;
    logic       parityError;
    logic [8:0] data;
  } rxEntry_t;

  function automatic rxEntry_t makeEntry(input logic brk, input logic parityError,
                                         input logic [8:0] data);
    rxEntry_t e;
    e.brk         = brk;
    e.parityError = parityError;
    e.data        = data;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host/receiver-facing signal bundle of uart_rx_ctrl.
//   master : the controller (drives config outputs, rxAck, FIFO head, status)
//   slave  : the environment (host + receiver datapath)
// Signals:
//   cfgWe/cfgData/cfgBusy                      host config write and apply-in-progress flag
//   rxRst, rxDataBits..rxClockDivisor          reset and applied config towards the receiver
//   rxData/rxDataReceived/rxParityError/rxBreak/rxOverflow/rxAck   receiver frame handshake
//   outData/outValid/outReady/fifoCount        FIFO head towards the host
//   stickyOverflow/stickyParity/statusClear    sticky status
interface uart_rx_ctrl_if #(
  parameter int unsigned CLOCK_DIVISOR_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH_LOG2     = 3
);
  import uart_pkg::*;

  logic                                       cfgWe;
  logic [CLOCK_DIVISOR_WIDTH+CfgCtrlBits-1:0] cfgData;
  logic                                       cfgBusy;

  logic                           rxRst;
  logic [1:0]                     rxDataBits;
  logic                           rxHasParity;
  logic [1:0]                     rxParityMode;
  logic                           rxExtraStopBit;
  logic [CLOCK_DIVISOR_WIDTH-1:0] rxClockDivisor;

  logic [8:0] rxData;
  logic       rxDataReceived;
  logic       rxParityError;
  logic       rxBreak;
  logic       rxOverflow;
  logic       rxAck;

  logic [FifoEntryWidth-1:0]  outData;
  logic                       outValid;
  logic                       outReady;
  logic [FIFO_DEPTH_LOG2:0]   fifoCount;

  logic stickyOverflow;
  logic stickyParity;
  logic statusClear;

  modport master (
    input  cfgWe, cfgData, rxData, rxDataReceived, rxParityError, rxBreak, rxOverflow,
           outReady, statusClear,
    output cfgBusy, rxRst, rxDataBits, rxHasParity, rxParityMode, rxExtraStopBit,
           rxClockDivisor, rxAck, outData, outValid, fifoCount, stickyOverflow, stickyParity
  );

  modport slave (
    output cfgWe, cfgData, rxData, rxDataReceived, rxParityError, rxBreak, rxOverflow,
           outReady, statusClear,
    input  cfgBusy, rxRst, rxDataBits, rxHasParity, rxParityMode, rxExtraStopBit,
           rxClockDivisor, rxAck, outData, outValid, fifoCount, stickyOverflow, stickyParity
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, 2**DEPTH_LOG2 entries of WIDTH bits, with occupancy count.
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push/pushData write request; accepted when not full, or when full and a pop happens too
//   pop/popData   read request; ignored when empty. popData is the head, meaningful when !empty
//   empty/full    occupancy flags
//   count         occupancy, DEPTH_LOG2+1 bits
module uart_sync_fifo #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  input  logic                  pop,
  output logic [WIDTH-1:0]      popData,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wrPtrQ;
  logic [DEPTH_LOG2-1:0] rdPtrQ;
  logic [DEPTH_LOG2:0]   countQ;
  logic                  doPush;
  logic                  doPop;

  always_comb begin
    doPop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    doPush = push && (!full || doPop);
  end

  // Pointers wrap naturally modulo the depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage carries no reset; entries are only observable through a valid count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ] <= pushData;
  end

  assign popData = mem[rdPtrQ];
  assign empty   = (countQ == '0);
  assign full    = (countQ == CntW'(Depth));
  assign count   = countQ;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Controller between the UART receiver datapath and a host.
//   - Host config is written into a shadow register and only reaches the receiver through a
//     two-cycle receiver reset (APPLY_RST, APPLY_WAIT), so the receiver never sees a config change
//     mid-frame.
//   - Every received frame is acknowledged exactly once and pushed, with its break and parity flags,
//     into an 8-entry FIFO; a frame arriving with the FIFO full (and not popping) is dropped.
//   - Sticky overflow/parity status, cleared by statusClear (a set in the same cycle wins).
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   bus        uart_rx_ctrl_if master modport (host config, receiver handshake, FIFO head, status)
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int unsigned CLOCK_DIVISOR_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH_LOG2     = 3
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.master bus
);

  localparam int unsigned W    = CLOCK_DIVISOR_WIDTH;
  localparam int unsigned CfgW = W + CfgCtrlBits;

  localparam logic [CfgW-1:0] RstCfg = {RstDataBits, RstHasParity, RstParityMode,
                                        RstExtraStopBit, {W{1'b0}}};

  rxCtrlState_e    stateQ;
  logic [CfgW-1:0] shadowCfgQ;
  logic [CfgW-1:0] appliedCfgQ;
  logic            rxRstQ;
  logic            cfgBusyQ;
  logic            rxAckQ;
  logic            stickyOvfQ;
  logic            stickyParQ;

  logic     fifoPush;
  logic     fifoPop;
  logic     fifoEmpty;
  logic     fifoFull;
  logic     dropFrame;
  rxEntry_t pushEntry;
  rxEntry_t headEntry;

  // ---------------------------------------------------------------------------------------------
  // Controller FSM. Outputs are registered and loaded with the value belonging to the state being
  // entered, so rxRst/cfgBusy are high exactly while the FSM sits in APPLY_RST/APPLY_WAIT and rxAck
  // is high exactly while it sits in ACK. cfgBusy resets to 0 even though reset enters APPLY_RST;
  // cfgWe is ignored outside IDLE anyway.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= StApplyRst;
      shadowCfgQ  <= RstCfg;
      appliedCfgQ <= RstCfg;
      rxRstQ      <= 1'b1;
      cfgBusyQ    <= 1'b0;
      rxAckQ      <= 1'b0;
    end else begin
      rxAckQ <= 1'b0;
      case (stateQ)
        StApplyRst: begin
          appliedCfgQ <= shadowCfgQ;
          rxRstQ      <= 1'b1;
          cfgBusyQ    <= 1'b1;
          stateQ      <= StApplyWait;
        end
        StApplyWait: begin
          rxRstQ   <= 1'b0;
          cfgBusyQ <= 1'b0;
          stateQ   <= StIdle;
        end
        StIdle: begin
          // A config write wins over a pending frame; the receiver reset discards that frame.
          if (bus.cfgWe) begin
            shadowCfgQ <= bus.cfgData;
            rxRstQ     <= 1'b1;
            cfgBusyQ   <= 1'b1;
            stateQ     <= StApplyRst;
          end else if (bus.rxDataReceived) begin
            rxAckQ <= 1'b1;
            stateQ <= StAck;
          end
        end
        StAck: begin
          stateQ <= StWaitClr;
        end
        StWaitClr: begin
          // The receiver keeps its valid level up until it sees the ack; never ack twice.
          if (!bus.rxDataReceived) stateQ <= StIdle;
        end
        default: begin
          rxRstQ   <= 1'b1;
          cfgBusyQ <= 1'b1;
          stateQ   <= StApplyRst;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame capture into the FIFO during ACK. A full FIFO still takes the frame when the host pops in
  // the same cycle; otherwise the frame is dropped and flagged as overflow.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    pushEntry = makeEntry(bus.rxBreak, bus.rxParityError, bus.rxData);
    fifoPop   = bus.outReady && !fifoEmpty;
    fifoPush  = 1'b0;
    dropFrame = 1'b0;
    if (stateQ == StAck) begin
      if (!fifoFull || fifoPop) fifoPush  = 1'b1;
      else                      dropFrame = 1'b1;
    end
  end

  uart_sync_fifo #(
    .WIDTH      (FifoEntryWidth),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .popData  (headEntry),
    .empty    (fifoEmpty),
    .full     (fifoFull),
    .count    (bus.fifoCount)
  );

  // ---------------------------------------------------------------------------------------------
  // Sticky status: a set condition in the same cycle as statusClear keeps the bit set.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stickyOvfQ <= 1'b0;
      stickyParQ <= 1'b0;
    end else begin
      if (bus.rxOverflow || dropFrame) stickyOvfQ <= 1'b1;
      else if (bus.statusClear)        stickyOvfQ <= 1'b0;

      if (fifoPush && bus.rxParityError) stickyParQ <= 1'b1;
      else if (bus.statusClear)          stickyParQ <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign bus.cfgBusy        = cfgBusyQ;
  assign bus.rxRst          = rxRstQ;
  assign bus.rxAck          = rxAckQ;
  assign bus.rxClockDivisor = appliedCfgQ[W-1:0];
  assign bus.rxExtraStopBit = appliedCfgQ[W+CfgExtraStopOfs];
  assign bus.rxParityMode   = appliedCfgQ[W+CfgParityModeOfs +: 2];
  assign bus.rxHasParity    = appliedCfgQ[W+CfgHasParityOfs];
  assign bus.rxDataBits     = appliedCfgQ[W+CfgDataBitsOfs +: 2];
  assign bus.outData        = headEntry;
  assign bus.outValid       = !fifoEmpty;
  assign bus.stickyOverflow = stickyOvfQ;
  assign bus.stickyParity   = stickyParQ;

endmodule
